// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side master for one port of a true dual-port block RAM. It fetches
//   a burst of consecutive words from a start address and presents them as
//   a valid/ready stream. The RAM's fixed read latency (1 or 2 cycles) is
//   absorbed by a tagged in-flight pipe and a small skid FIFO.
//
// Parameters
//   DATA_WIDTH    RAM word width
//   ADDR_WIDTH    RAM address width (depth = 2**ADDR_WIDTH)
//   READ_LATENCY  RAM read latency, 1 (no output register) or 2 (output register)
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start                burst request, only honoured while busy=0
//   start_addr, length   first address and word count (0..2**ADDR_WIDTH)
//   busy, done           burst in progress / one-cycle completion pulse
//   ram_addr, ram_we     RAM port address (registered) and write enable (always 0)
//   ram_dout             RAM port read data
//   m_valid/m_ready      output stream handshake
//   m_data, m_last       stream data and final-beat marker
module ram_burst_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [PTR_W-1:0]      PTR_ONE   = 1;
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
    localparam logic [3:0]            OCC_LIMIT = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;

    // Stage 0 tags the address currently on ram_addr; stage READ_LATENCY
    // tags the word currently on ram_dout, which is pushed at this edge.
    logic [READ_LATENCY:0]   r_vld_pipe;
    logic [READ_LATENCY:0]   r_last_pipe;

    logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
    logic                    r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_cnt;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_issue_rd;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_push;
    logic                    w_pop;
    logic [3:0]              w_occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_vld_pipe[READ_LATENCY];

    // Words already committed to arrive (tagged in the pipe) plus words held,
    // net of the one leaving this edge. Keeping this below the FIFO depth
    // before issuing guarantees every issued word has a slot even if m_ready
    // stays low forever, while still allowing one issue per cycle when the
    // consumer drains one per cycle.
    assign w_occ = 4'($countones(r_vld_pipe)) + 4'(r_fifo_cnt) - 4'(w_pop);

    // A start is only seen while not busy; the first read goes out on the
    // acceptance edge so the address is on the bus in the next cycle.
    assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_first      = w_accept && (length != '0);
    assign w_issue_rd   = (r_state == S_READ) && (r_remaining != '0) && (w_occ < OCC_LIMIT);
    assign w_issue      = w_first || w_issue_rd;
    assign w_issue_last = w_first ? (length == LEN_ONE) : (r_remaining == LEN_ONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_state_nxt = (length == '0) ? S_DONE : S_READ;
                else if (r_state == S_DONE)
                    w_state_nxt = S_IDLE;
            end
            S_READ: begin
                if ((r_remaining == '0) || (w_issue_rd && (r_remaining == LEN_ONE)))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The last-tagged word is the final one issued, so once it is
                // handed over nothing remains in flight or in the FIFO.
                if (w_pop && m_last)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            r_state <= w_state_nxt;

            // ram_addr holds when idle; the RAM keeps reading it, but those
            // words carry no tag and are never captured.
            if (w_issue) begin
                r_addr      <= w_first ? start_addr : r_addr + ADDR_ONE;
                r_remaining <= w_first ? length - LEN_ONE : r_remaining - LEN_ONE;
            end

            r_vld_pipe  <= {r_vld_pipe[READ_LATENCY-1:0], w_issue};
            r_last_pipe <= {r_last_pipe[READ_LATENCY-1:0], w_issue && w_issue_last};

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_dout;
                r_fifo_last[r_wr_ptr] <= r_last_pipe[READ_LATENCY];
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);

            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign busy     = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign ram_addr = r_addr;
    assign ram_we   = 1'b0;
    assign m_valid  = (r_fifo_cnt != '0);
    assign m_data   = r_fifo_data[r_rd_ptr];
    assign m_last   = m_valid && r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader. Two instances run side by side, one with
// READ_LATENCY=1 and one with READ_LATENCY=2, each behind its own RAM model
// and driven by its own stimulus thread with identical burst lists.
module tb_ram_burst_reader;

    localparam int DW   = 8;
    localparam int AW   = 9;
    localparam int DEP  = 1 << AW;
    localparam int NB   = 32;

    logic clk;
    logic rstn;

    logic          start_v    [2];
    logic [AW-1:0] saddr      [2];
    logic [AW:0]   slen       [2];
    logic          rdy        [2];
    logic          real_start [2];

    logic          busy_o [2];
    logic          done_o [2];
    logic [AW-1:0] raddr  [2];
    logic          we_o   [2];
    logic [DW-1:0] rdout  [2];
    logic          mv     [2];
    logic [DW-1:0] md     [2];
    logic          ml     [2];

    logic [DW-1:0] mem [DEP];

    logic expect_zero;
    logic final_chk;

    int n_tests;
    int n_fail;
    int cyc;

    logic [DW:0] exp_q [2][$];

    int b_addr [NB];
    int b_len  [NB];
    int b_mode [NB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int RL = g + 1;
        logic [DW-1:0] rpipe [RL];

        always @(posedge clk) begin
            rpipe[0] <= mem[raddr[g]];
            for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
        end
        assign rdout[g] = rpipe[RL-1];

        ram_burst_reader #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .READ_LATENCY(RL)
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .start     (start_v[g]),
            .start_addr(saddr[g]),
            .length    (slen[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .ram_addr  (raddr[g]),
            .ram_we    (we_o[g]),
            .ram_dout  (rdout[g]),
            .m_valid   (mv[g]),
            .m_ready   (rdy[g]),
            .m_data    (md[g]),
            .m_last    (ml[g])
        );
    end

    // ---------------- monitor / scoreboard ----------------
    bit          last_hs_prev [2];
    bit          zl_prev      [2];
    bit          stall_prev   [2];
    bit          first_pend   [2];
    bit          nostall      [2];
    int          t_acc        [2];
    int          t_first      [2];
    int          len_lat      [2];
    int          beats        [2];
    logic [DW:0] held         [2];

    task automatic chk(input string nm, input int l, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s lane%0d cyc=%0d: got %0h expected %0h", nm, l, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        bit          hs;
        bit          exp_done;
        logic [DW:0] e;
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (!rstn) begin
                exp_q[l].delete();
                last_hs_prev[l] = 1'b0;
                zl_prev[l]      = 1'b0;
                stall_prev[l]   = 1'b0;
                first_pend[l]   = 1'b0;
                nostall[l]      = 1'b0;
                beats[l]        = 0;
            end else begin
                if (expect_zero)
                    chk("reset_outputs", l,
                        {busy_o[l], done_o[l], raddr[l], mv[l], md[l], ml[l]}, 0);
                if (final_chk)
                    chk("queue_drained", l, exp_q[l].size(), 0);

                exp_done = last_hs_prev[l] || zl_prev[l];
                if (done_o[l] || exp_done) begin
                    chk("done_pulse", l, done_o[l], exp_done);
                    chk("busy_in_done", l, busy_o[l], 0);
                    chk("ram_we_low", l, we_o[l], 0);
                end

                if (stall_prev[l])
                    chk("stall_hold", l, {mv[l], ml[l], md[l]}, {1'b1, held[l]});

                if (first_pend[l] && mv[l]) begin
                    chk("first_latency", l, cyc - t_acc[l], l + 3);
                    t_first[l]    = cyc;
                    first_pend[l] = 1'b0;
                end

                hs = mv[l] && rdy[l];
                last_hs_prev[l] = 1'b0;
                if (hs) begin
                    if (exp_q[l].size() == 0) begin
                        chk("unexpected_beat", l, {ml[l], md[l]}, -1);
                    end else begin
                        e = exp_q[l].pop_front();
                        chk("beat", l, {ml[l], md[l]}, e);
                        beats[l]++;
                        last_hs_prev[l] = e[DW];
                        if (e[DW] && nostall[l])
                            chk("no_bubbles", l, cyc - t_first[l], len_lat[l] - 1);
                    end
                end

                if (!rdy[l]) nostall[l] = 1'b0;
                stall_prev[l] = mv[l] && !rdy[l];
                held[l]       = {ml[l], md[l]};
                zl_prev[l]    = real_start[l] && (slen[l] == 0);
                if (real_start[l] && slen[l] != 0) begin
                    first_pend[l] = 1'b1;
                    t_acc[l]      = cyc;
                    len_lat[l]    = int'(slen[l]);
                    nostall[l]    = 1'b1;
                    beats[l]      = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int l, input int a, input int n);
        for (int k = 0; k < n; k++)
            exp_q[l].push_back({1'(k == n - 1), mem[(a + k) % DEP]});
    endtask

    // Runs bursts b0..b0+nb-1 back to back on one lane; each next burst is
    // requested in the cycle the previous one reports done.
    task automatic lane_run(input int l, input int b0, input int nb);
        for (int i = b0; i < b0 + nb; i++) begin
            int  a;
            int  n;
            int  m;
            int  k;
            bit  fin;
            a = b_addr[i];
            n = b_len[i];
            m = b_mode[i];
            push_exp(l, a, n);
            saddr[l]      = AW'(a);
            slen[l]       = (AW+1)'(n);
            start_v[l]    = 1'b1;
            real_start[l] = 1'b1;
            if (n == 0) begin
                rdy[l] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                start_v[l]    = 1'b0;
                real_start[l] = 1'b0;
                continue;
            end
            k   = 0;
            fin = 1'b0;
            while (!fin) begin
                if (k > 0) begin
                    start_v[l]    = 1'b0;
                    real_start[l] = 1'b0;
                end
                if (k == 5 && n >= 8) begin
                    start_v[l] = 1'b1;
                    saddr[l]   = AW'($urandom_range(0, DEP - 1));
                    slen[l]    = (AW+1)'($urandom_range(1, DEP));
                end
                case (m)
                    0:       rdy[l] = 1'b1;
                    1:       rdy[l] = ((k % 4) == 0) || ((k % 4) == 3);
                    default: rdy[l] = ($urandom_range(0, 3) != 0);
                endcase
                @(negedge clk);
                if (mv[l] && rdy[l] && ml[l]) fin = 1'b1;
                @(posedge clk); #1;
                k++;
                if (k > n * 8 + 40) begin
                    $display("FAIL burst_timeout lane%0d burst %0d: no final beat after %0d cycles",
                             l, i, k);
                    $fatal(1, "burst timeout");
                end
            end
        end
        start_v[l]    = 1'b0;
        real_start[l] = 1'b0;
    endtask

    initial begin
        int w;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        expect_zero = 1'b0;
        final_chk   = 1'b0;
        rstn        = 1'b0;
        for (int l = 0; l < 2; l++) begin
            start_v[l]    = 1'b0;
            real_start[l] = 1'b0;
            saddr[l]      = '0;
            slen[l]       = '0;
            rdy[l]        = 1'b0;
        end
        for (int i = 0; i < DEP; i++) mem[i] = DW'(i);

        // directed list: basic, stalled, wrap, empty, full + mid start, back-to-back
        b_addr[0] = 'h010; b_len[0] = 4;   b_mode[0] = 0;
        b_addr[1] = 'h000; b_len[1] = 8;   b_mode[1] = 1;
        b_addr[2] = 'h1FE; b_len[2] = 4;   b_mode[2] = 0;
        b_addr[3] = 'h040; b_len[3] = 0;   b_mode[3] = 0;
        b_addr[4] = 'h123; b_len[4] = 512; b_mode[4] = 0;
        b_addr[5] = 'h050; b_len[5] = 5;   b_mode[5] = 0;
        b_addr[6] = 'h030; b_len[6] = 6;   b_mode[6] = 2;
        for (int i = 7; i < NB; i++) begin
            b_addr[i] = $urandom_range(0, DEP - 1);
            b_len[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEP)
                                                    : $urandom_range(0, 24);
            b_mode[i] = $urandom_range(0, 2);
        end

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        expect_zero = 1'b1;
        @(posedge clk); #1 expect_zero = 1'b0;

        fork
            lane_run(0, 0, 6);
            lane_run(1, 0, 6);
        join
        repeat (4) @(posedge clk);
        #1;

        // reset in the middle of an 8-beat burst
        for (int l = 0; l < 2; l++) begin
            push_exp(l, 'h020, 8);
            saddr[l]      = AW'('h020);
            slen[l]       = (AW+1)'(8);
            start_v[l]    = 1'b1;
            real_start[l] = 1'b1;
            rdy[l]        = 1'b1;
        end
        @(posedge clk); #1;
        for (int l = 0; l < 2; l++) begin
            start_v[l]    = 1'b0;
            real_start[l] = 1'b0;
        end
        w = 0;
        while (beats[0] < 3) begin
            @(posedge clk); #1;
            w++;
            if (w > 100) begin
                $display("FAIL reset_setup_timeout lane0: beats %0d expected 3", beats[0]);
                $fatal(1, "timeout");
            end
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn        = 1'b1;
        expect_zero = 1'b1;
        @(posedge clk); #1 expect_zero = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        fork
            lane_run(0, 6, 1);
            lane_run(1, 6, 1);
        join
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
        fork
            lane_run(0, 7, NB - 7);
            lane_run(1, 7, NB - 7);
        join

        repeat (5) @(posedge clk);
        #1 final_chk = 1'b1;
        @(posedge clk); #1 final_chk = 1'b0;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side master for the true dual-port block RAM.
- Drives one RAM port's address and write enable. The write enable is tied low.
- Fetches a burst of consecutive words from a start address, absorbs the RAM's fixed read latency (1 or 2 cycles), and presents the data as a valid/ready stream with backpressure.
- Sits between a frame/line buffer RAM and downstream vision/inference stages.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 9, RAM address width; depth = 2**ADDR_WIDTH.
- READ_LATENCY, 1, RAM read latency in cycles. 1 = no output register; 2 = output register enabled. Other values are illegal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  burst request; sampled only when busy=0.
- start_addr  in  ADDR_WIDTH  first RAM address of the burst.
- length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_we  out  1  RAM port write enable; constant 0.
- ram_dout  in  DATA_WIDTH  RAM port read data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks the final beat of the burst.

Behaviour:
- Interface decision: one clock (clk); reset rstn is synchronous and active-low. While rstn=0 at a clock edge, every register clears.
- Reset values: busy=0, done=0, ram_addr=0, m_valid=0, m_data=0, m_last=0. The skid FIFO, in-flight pipe and counters all clear.
- Reset mid-burst abandons the burst. No done pulse is produced, and in-flight RAM data is discarded.
- States:
  - IDLE: busy=0. On start with length>0 -> READ. On start with length=0 -> DONE, with no reads and busy staying 0.
  - READ: busy=1; issues reads. After the last issue -> DRAIN.
  - DRAIN: busy=1; waits for in-flight reads and the FIFO to empty after the m_last handshake, then -> DONE.
  - DONE: done=1, busy=0; one cycle, then -> IDLE. A start seen in the DONE cycle is accepted, giving back-to-back bursts.
- Start handling: start while busy=1 is ignored. start_addr and length are latched at acceptance in cycle T.
- Issue rule: in READ, a read is issued in a cycle iff remaining>0 and (inflight+fifo_count) < READ_LATENCY+2.
  - An issue places the next address on ram_addr, which is a registered output.
  - The first address appears in cycle T+1.
  - The address increments by 1 per issue, modulo 2**ADDR_WIDTH, so the burst wraps from max address to 0.
- ram_addr holds its value when not issuing; the resulting extra RAM reads are discarded.
- In-flight tracking: a READ_LATENCY-deep valid/last shift pipe tags each issued address.
  - ram_dout is captured into the skid FIFO at the edge READ_LATENCY cycles after its address edge.
  - Skid FIFO: depth READ_LATENCY+2, width DATA_WIDTH+1 (data plus last flag).
  - By construction the FIFO never overflows, even with m_ready held low indefinitely.
- Output rules:
  - m_valid=1 whenever the FIFO is non-empty; m_data and m_last come from the FIFO head.
  - Pop on m_valid&&m_ready.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Latency: the first beat has m_valid=1 in cycle T+2+READ_LATENCY.
- Throughput: with m_ready=1 continuously, one beat per cycle with no bubbles.
- m_last=1 only on beat index length-1.
- done pulses in the cycle after the m_last handshake.

Test Plan:
- READ_LATENCY=1, RAM[i]=i[7:0], start_addr=0x010, length=4, m_ready=1 -> m_valid first in cycle T+3; beats 0x10,0x11,0x12,0x13 on consecutive cycles; m_last only on 0x13; done one cycle later; busy 0 after.
- READ_LATENCY=2, length=8 from 0x000, m_ready toggling 1,0,0,1 pattern -> beats 0x00..0x07 in order with no loss or duplication; data held stable while stalled; FIFO occupancy ≤ 4.
- Wrap-around: start_addr=0x1FE, length=4 -> ram_addr sequence 0x1FE,0x1FF,0x000,0x001; beats FE,FF,00,01.
- length=0 -> no m_valid ever; done pulses in T+1; busy stays 0.
- Full burst length=512 with m_ready=1 -> exactly 512 beats in 512 consecutive cycles; a start pulse mid-burst is ignored; a start in the done cycle launches the next burst.
- rstn=0 for one cycle after 3 of 8 beats -> all outputs return to reset values next cycle; no further beats; no done pulse; a new start afterwards completes normally.
